// File: rtl/rvl_mem_arb.sv
// Round-robin arbiter sharing the user port (B) of the Reveal mailbox RAM
// between NUM_REQ requesters, with bounded bursts and per-requester read return.

module rvl_mem_arb_lane #(
  parameter int PW   = 1,
  parameter int LANE = 0
) (
  input  logic [PW-1:0] owner_i,
  input  logic          issue_i,
  input  logic [PW-1:0] rd_owner_i,
  input  logic          rvalid_i,
  output logic          ack_o,
  output logic          rvalid_o
);
  assign ack_o    = issue_i  && (owner_i    == PW'(LANE));
  assign rvalid_o = rvalid_i && (rd_owner_i == PW'(LANE));
endmodule

module rvl_mem_arb #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int MAX_BURST  = 4
) (
  input  logic                           usr_clk,
  input  logic                           usr_rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             ack,
  output logic [NUM_REQ-1:0]             rvalid,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic                           mem_ce,
  output logic                           mem_we,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic [DATA_WIDTH-1:0]          mem_wdata,
  input  logic [DATA_WIDTH-1:0]          mem_rdata
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]    burst_q, burst_d;
  logic          rvalid_q;
  logic [PW-1:0] rd_owner_q;

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_a;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_a;
  logic [NUM_REQ-1:0]                 others;
  logic                               issue, rd_issue, last_beat, rotate;

  assign addr_a  = req_addr;
  assign wdata_a = req_wdata;

  // Wrap explicitly: NUM_REQ=3 leaves pointer code 3 unused.
  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    inc_ptr = (p == PW'(NUM_REQ-1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] pick(input logic [NUM_REQ-1:0] v,
                                         input logic [PW-1:0]      start);
    logic found;
    int   s;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = int'(start) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      if (!found && v[PW'(s)]) begin
        pick  = PW'(s);
        found = 1'b1;
      end
    end
  endfunction

  always_comb begin
    others          = req;
    others[owner_q] = 1'b0;
  end

  assign issue     = (state_q == GRANT) && req[owner_q];
  assign rd_issue  = issue && !req_we[owner_q];
  assign last_beat = (burst_q == 8'(MAX_BURST-1));
  assign rotate    = (state_q == GRANT) && (!req[owner_q] || (last_beat && |others));

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = pick(req, rr_ptr_q);
          burst_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (rotate) begin
          rr_ptr_d = inc_ptr(owner_q);
          if (|others) begin
            owner_d = pick(others, inc_ptr(owner_q));
            burst_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (issue) begin
          // A lone owner parks at the last beat and keeps the grant.
          burst_d = last_beat ? burst_q : burst_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      burst_q    <= '0;
      rvalid_q   <= 1'b0;
      rd_owner_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
      rvalid_q <= rd_issue;
      if (rd_issue) rd_owner_q <= owner_q;
    end
  end

  assign mem_ce    = issue;
  assign mem_we    = issue && req_we[owner_q];
  assign mem_addr  = addr_a[owner_q];
  assign mem_wdata = wdata_a[owner_q];
  assign rdata     = mem_rdata;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    rvl_mem_arb_lane #(.PW(PW), .LANE(g)) u_lane (
      .owner_i    (owner_q),
      .issue_i    (issue),
      .rd_owner_i (rd_owner_q),
      .rvalid_i   (rvalid_q),
      .ack_o      (ack[g]),
      .rvalid_o   (rvalid[g])
    );
  end

endmodule
